// File: rtl/i2c_responder.sv
// I2C write-only register target: address byte, index/data-MSB byte, data-LSB byte.
// Commits a 9-bit write into a flat register file; index 7'h0F clears every register.
module i2c_responder #(
    parameter logic [6:0] P_DEV_ADDR = 7'h1A,
    parameter int         P_NUM_REGS = 10
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_scl,
    input  logic                    i_sda,
    output logic                    o_sda_oe,
    output logic                    o_wr_valid,
    output logic [6:0]              o_wr_addr,
    output logic [8:0]              o_wr_data,
    output logic [9*P_NUM_REGS-1:0] o_regs,
    output logic                    o_err,
    output logic                    o_busy,
    output logic [4:0]              o_wr_cnt,
    output logic [2:0]              o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ACK_A, S_BYTE1, S_ACK_1, S_BYTE2, S_ACK_2, S_WAIT_STOP
    } state_t;

    localparam logic [6:0] CLEAR_IDX = 7'h0F;

    logic scl_meta, scl_q, scl_d;
    logic sda_meta, sda_q, sda_d;

    // Synchronizer stages preset high so reset never looks like a bus edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scl_meta <= 1'b1;
            scl_q    <= 1'b1;
            scl_d    <= 1'b1;
            sda_meta <= 1'b1;
            sda_q    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_meta <= i_scl;
            scl_q    <= scl_meta;
            scl_d    <= scl_q;
            sda_meta <= i_sda;
            sda_q    <= sda_meta;
            sda_d    <= sda_q;
        end
    end

    logic start_det, stop_det, scl_rise, scl_fall;
    assign start_det = scl_q & scl_d & sda_d & ~sda_q;
    assign stop_det  = scl_q & scl_d & ~sda_d & sda_q;
    assign scl_rise  = ~scl_d & scl_q;
    assign scl_fall  = scl_d & ~scl_q;

    state_t      state_q, state_nxt;
    logic [3:0]  bit_cnt_q, bit_cnt_nxt;
    logic [7:0]  shift_q, shift_nxt;
    logic [6:0]  idx_q, idx_nxt;
    logic        d8_q, d8_nxt;
    logic        sda_oe_q, sda_oe_nxt;
    logic        commit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= 4'd0;
            shift_q   <= 8'd0;
            idx_q     <= 7'd0;
            d8_q      <= 1'b0;
            sda_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            bit_cnt_q <= bit_cnt_nxt;
            shift_q   <= shift_nxt;
            idx_q     <= idx_nxt;
            d8_q      <= d8_nxt;
            sda_oe_q  <= sda_oe_nxt;
        end
    end

    always_comb begin
        state_nxt   = state_q;
        bit_cnt_nxt = bit_cnt_q;
        shift_nxt   = shift_q;
        idx_nxt     = idx_q;
        d8_nxt      = d8_q;
        sda_oe_nxt  = sda_oe_q;
        commit      = 1'b0;
        if (start_det) begin
            state_nxt   = S_ADDR;
            bit_cnt_nxt = 4'd0;
            sda_oe_nxt  = 1'b0;
        end else if (stop_det) begin
            state_nxt   = S_IDLE;
            bit_cnt_nxt = 4'd0;
            sda_oe_nxt  = 1'b0;
        end else begin
            case (state_q)
                S_ADDR, S_BYTE1, S_BYTE2: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        shift_nxt   = {shift_q[6:0], sda_q};
                        bit_cnt_nxt = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        // The fall ending bit 8 starts the ACK slot.
                        bit_cnt_nxt = 4'd0;
                        case (state_q)
                            S_ADDR: begin
                                if (shift_q[7:1] == P_DEV_ADDR && !shift_q[0]) begin
                                    state_nxt  = S_ACK_A;
                                    sda_oe_nxt = 1'b1;
                                end else begin
                                    state_nxt  = S_WAIT_STOP;
                                end
                            end
                            S_BYTE1: begin
                                idx_nxt    = shift_q[7:1];
                                d8_nxt     = shift_q[0];
                                state_nxt  = S_ACK_1;
                                sda_oe_nxt = 1'b1;
                            end
                            default: begin
                                state_nxt  = S_ACK_2;
                                sda_oe_nxt = 1'b1;
                                commit     = 1'b1;
                            end
                        endcase
                    end
                end
                S_ACK_A, S_ACK_1, S_ACK_2: begin
                    if (scl_fall) begin
                        sda_oe_nxt = 1'b0;
                        case (state_q)
                            S_ACK_A: state_nxt = S_BYTE1;
                            S_ACK_1: state_nxt = S_BYTE2;
                            default: state_nxt = S_WAIT_STOP;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    logic [8:0] regs_q [P_NUM_REGS];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_wr_valid <= 1'b0;
            o_err      <= 1'b0;
            o_wr_addr  <= 7'd0;
            o_wr_data  <= 9'd0;
            o_wr_cnt   <= 5'd0;
            for (int n = 0; n < P_NUM_REGS; n++) regs_q[n] <= 9'd0;
        end else begin
            o_wr_valid <= 1'b0;
            o_err      <= 1'b0;
            if (commit) begin
                if (idx_q == CLEAR_IDX || {25'd0, idx_q} < 32'(P_NUM_REGS)) begin
                    o_wr_valid <= 1'b1;
                    o_wr_addr  <= idx_q;
                    o_wr_data  <= {d8_q, shift_q};
                    if (o_wr_cnt != 5'd31) o_wr_cnt <= o_wr_cnt + 5'd1;
                    for (int n = 0; n < P_NUM_REGS; n++) begin
                        if (idx_q == CLEAR_IDX) regs_q[n] <= 9'd0;
                        else if (idx_q == 7'(n)) regs_q[n] <= {d8_q, shift_q};
                    end
                end else begin
                    o_err <= 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < P_NUM_REGS; g++) begin : g_flat
        assign o_regs[9*g +: 9] = regs_q[g];
    end

    assign o_sda_oe    = sda_oe_q;
    assign o_busy      = (state_q != S_IDLE);
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_i2c_responder.sv
// Bench for i2c_responder: bit-banged I2C master on a wired-AND SDA, write
// scoreboard fed by a register-file model.
module tb_i2c_responder;

    localparam int NR = 10;
    localparam int HP = 10;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            scl_m;
    logic            sda_m;
    logic            sda_bus;
    logic            sda_oe;
    logic            wr_valid;
    logic [6:0]      wr_addr;
    logic [8:0]      wr_data;
    logic [9*NR-1:0] regs;
    logic            err;
    logic            busy;
    logic [4:0]      wr_cnt;
    logic [2:0]      dbg_state;

    assign sda_bus = sda_m & ~sda_oe;

    i2c_responder #(.P_DEV_ADDR(7'h1A), .P_NUM_REGS(NR)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_scl      (scl_m),
        .i_sda      (sda_bus),
        .o_sda_oe   (sda_oe),
        .o_wr_valid (wr_valid),
        .o_wr_addr  (wr_addr),
        .o_wr_data  (wr_data),
        .o_regs     (regs),
        .o_err      (err),
        .o_busy     (busy),
        .o_wr_cnt   (wr_cnt),
        .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          err_seen = 0;
    int          exp_err = 0;
    logic [4:0]  exp_cnt = 5'd0;
    logic [8:0]  exp_regs [NR];
    logic [15:0] exp_q [$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Write scoreboard: every valid pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_valid) begin
                if (exp_q.size() == 0) chk("wr_spurious", 128'(exp_q.size()), 128'(1));
                else chk("wr_pair", 128'({wr_addr, wr_data}), 128'(exp_q.pop_front()));
            end
            if (err) err_seen++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start;
        sda_m = 1'b1; tick(HP);
        scl_m = 1'b1; tick(HP);
        sda_m = 1'b0; tick(HP);
        scl_m = 1'b0; tick(HP/2);
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0; tick(HP);
        scl_m = 1'b1; tick(HP);
        sda_m = 1'b1; tick(HP);
    endtask

    task automatic i2c_bit(input logic b);
        sda_m = b;    tick(HP);
        scl_m = 1'b1; tick(HP);
        scl_m = 1'b0; tick(HP/2);
    endtask

    task automatic i2c_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) i2c_bit(b[i]);
        sda_m = 1'b1; tick(HP);
        scl_m = 1'b1; tick(HP/2);
        ack = sda_oe;
        tick(HP/2);
        scl_m = 1'b0; tick(HP/2);
    endtask

    function automatic logic [9*NR-1:0] flat_regs();
        logic [9*NR-1:0] f;
        for (int n = 0; n < NR; n++) f[9*n +: 9] = exp_regs[n];
        return f;
    endfunction

    task automatic model_write(input logic [6:0] idx, input logic [8:0] d);
        if (idx == 7'h0F || idx < 7'(NR)) begin
            exp_q.push_back({idx, d});
            if (exp_cnt != 5'd31) exp_cnt++;
            for (int n = 0; n < NR; n++) begin
                if (idx == 7'h0F) exp_regs[n] = 9'd0;
                else if (idx == 7'(n)) exp_regs[n] = d;
            end
        end else begin
            exp_err++;
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_regs"}, 128'(regs), 128'(flat_regs()));
        chk({tag, "_cnt"}, 128'(wr_cnt), 128'(exp_cnt));
        chk({tag, "_err"}, 128'(err_seen), 128'(exp_err));
        chk({tag, "_drained"}, 128'(exp_q.size()), 128'(0));
        chk({tag, "_idle"}, 128'(busy), 128'(0));
    endtask

    task automatic frame(input string tag, input logic [7:0] ab, input logic [7:0] b1,
                         input logic [7:0] b2, input bit extra);
        logic ack;
        logic match;
        match = (ab == 8'h34);
        if (match) model_write(b1[7:1], {b1[0], b2});
        i2c_start;
        chk({tag, "_busy"}, 128'(busy), 128'(1));
        i2c_byte(ab, ack); chk({tag, "_ack_a"}, 128'(ack), 128'(match));
        i2c_byte(b1, ack); chk({tag, "_ack_1"}, 128'(ack), 128'(match));
        i2c_byte(b2, ack); chk({tag, "_ack_2"}, 128'(ack), 128'(match));
        if (extra) begin
            i2c_byte(8'h5A, ack); chk({tag, "_ack_x"}, 128'(ack), 128'(0));
        end
        i2c_stop;
        tick(HP);
        check_state(tag);
    endtask

    task automatic reset_model;
        for (int n = 0; n < NR; n++) exp_regs[n] = 9'd0;
        exp_cnt = 5'd0;
        exp_q.delete();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_oe"}, 128'(sda_oe), 128'(0));
        chk({tag, "_valid"}, 128'(wr_valid), 128'(0));
        chk({tag, "_err"}, 128'(err), 128'(0));
        chk({tag, "_busy"}, 128'(busy), 128'(0));
        chk({tag, "_cnt"}, 128'(wr_cnt), 128'(0));
        chk({tag, "_addr"}, 128'(wr_addr), 128'(0));
        chk({tag, "_data"}, 128'(wr_data), 128'(0));
        chk({tag, "_regs"}, 128'(regs), 128'(0));
        chk({tag, "_state"}, 128'(dbg_state), 128'(0));
    endtask

    initial begin
        logic ack;
        logic [6:0] ridx;
        logic [8:0] rdat;
        reset_model();
        rst_n = 1'b0;
        scl_m = 1'b1;
        sda_m = 1'b1;
        tick(5);
        check_reset_values("rst");
        rst_n = 1'b1;
        tick(HP);

        // Bus wiggles with SDA changing only while SCL is low: no START seen.
        scl_m = 1'b0; tick(HP);
        sda_m = 1'b0; tick(HP);
        scl_m = 1'b1; tick(HP);
        scl_m = 1'b0; tick(HP);
        sda_m = 1'b1; tick(HP);
        scl_m = 1'b1; tick(HP);
        chk("idle_noise_busy", 128'(busy), 128'(0));
        chk("idle_noise_state", 128'(dbg_state), 128'(0));

        frame("w_r0", 8'h34, 8'h00, 8'h97, 1'b0);
        frame("w_r7", 8'h34, 8'h0E, 8'h42, 1'b0);
        frame("clear", 8'h34, 8'h1E, 8'h00, 1'b0);
        frame("w_r2", 8'h34, 8'h05, 8'hA5, 1'b0);
        frame("nack36", 8'h36, 8'h01, 8'h23, 1'b0);
        frame("nack35", 8'h35, 8'h01, 8'h23, 1'b0);

        // Frame abandoned after byte 1 by STOP.
        i2c_start;
        i2c_byte(8'h34, ack); chk("part_ack_a", 128'(ack), 128'(1));
        i2c_byte(8'h00, ack); chk("part_ack_1", 128'(ack), 128'(1));
        i2c_stop;
        tick(HP);
        check_state("part");

        // Frame abandoned after byte 1 by a repeated START that carries a real write.
        i2c_start;
        i2c_byte(8'h34, ack);
        i2c_byte(8'h00, ack);
        frame("rs_r1", 8'h34, 8'h02, 8'h79, 1'b0);

        frame("idx10", 8'h34, 8'h14, 8'h55, 1'b0);
        frame("extra", 8'h34, 8'h08, 8'h11, 1'b1);

        for (int k = 0; k < 30; k++) begin
            ridx = 7'($urandom_range(0, NR - 1));
            rdat = 9'($urandom_range(0, 511));
            frame("rand", 8'h34, {ridx, rdat[8]}, rdat[7:0], 1'b0);
        end
        chk("cnt_saturated", 128'(wr_cnt), 128'(31));

        // Reset asserted while SCL is high during bit 4 of byte 2.
        i2c_start;
        i2c_byte(8'h34, ack);
        i2c_byte(8'h0C, ack);
        for (int i = 0; i < 3; i++) i2c_bit(1'b1);
        sda_m = 1'b0; tick(HP);
        scl_m = 1'b1; tick(3);
        rst_n = 1'b0;
        #1;
        reset_model();
        check_reset_values("midrst");
        sda_m = 1'b1;
        tick(HP);
        rst_n = 1'b1;
        tick(HP);
        check_state("midrst_after");
        frame("post_rst", 8'h34, 8'h06, 8'h3C, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
